// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator and its phase timer.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StDone,
    StGap
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SpiMode = 2'b00;

  localparam int unsigned DefaultHalfPeriod = 4;

  function automatic int unsigned len_width(input int unsigned data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period down-counter: runs HalfPeriod-1..0 while enabled, pulses tc_o on the last
// cycle of each half period and wraps.
module spi_phase_timer
  import spi_pkg::*;
#(
  parameter int unsigned HalfPeriod = DefaultHalfPeriod
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic en_i,
  output logic tc_o,
  output logic near_tc_o
);

  localparam int unsigned CntW = (HalfPeriod > 2) ? $clog2(HalfPeriod) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(HalfPeriod - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || (en_i && (cnt_q == '0))) begin
      cnt_d = Reload;
    end else if (en_i) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o      = en_i && (cnt_q == '0);
  assign near_tc_o = en_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/spi_initiator.sv
// SPI mode (0,0) initiator: full-duplex, MSB-first, up to DATA_WIDTH bits per request.
// Define SPI_INITIATOR_BURST_EN to chain words under one cs_n assertion.
module spi_initiator
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned HALF_PERIOD = DefaultHalfPeriod,
  parameter int unsigned LEN_WIDTH   = len_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [LEN_WIDTH-1:0]  tx_len,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic                  cs_n
);

`ifdef SPI_INITIATOR_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  localparam logic [LEN_WIDTH-1:0] MaxLen  = LEN_WIDTH'(DATA_WIDTH);
  localparam logic                 SckIdle = SpiMode[1];

  spi_state_e            state_d, state_q;
  logic [DATA_WIDTH-1:0] tx_sh_d, tx_sh_q;
  logic [DATA_WIDTH-1:0] rx_sh_d, rx_sh_q;
  logic [LEN_WIDTH-1:0]  bit_cnt_d, bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_data_d, rx_data_q;
  logic                  rx_valid_d, rx_valid_q;
  logic                  cs_n_d, cs_n_q;
  logic                  sck_d, sck_q;
  logic                  sdo_d, sdo_q;
  logic                  busy_d, busy_q;
  logic                  tx_ready_d, tx_ready_q;

  logic                  accept;
  logic [LEN_WIDTH-1:0]  len_c;
  logic                  timer_restart, timer_en, tc, near_tc;

  assign accept        = tx_valid && tx_ready_q;
  assign len_c         = (tx_len > MaxLen) ? MaxLen : tx_len;
  assign timer_restart = (state_q == StIdle) || (state_q == StDone);
  assign timer_en      = !timer_restart;

  spi_phase_timer #(
    .HalfPeriod(HALF_PERIOD)
  ) u_phase_timer (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .restart_i(timer_restart),
    .en_i     (timer_en),
    .tc_o     (tc),
    .near_tc_o(near_tc)
  );

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    // Left-align the word so the first bit to send always sits at the MSB.
    if (accept) begin
      tx_sh_d   = tx_data << (MaxLen - len_c);
      rx_sh_d   = '0;
      bit_cnt_d = len_c;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (len_c == '0) begin
            state_d    = StDone;
            rx_data_d  = '0;
            rx_valid_d = 1'b1;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup, StLow: begin
        // sck rises on this edge, so sdi is captured here too.
        if (tc) begin
          state_d   = StHigh;
          bit_cnt_d = bit_cnt_q - LEN_WIDTH'(1);
          rx_sh_d   = {rx_sh_q[DATA_WIDTH-2:0], sdi};
        end
      end
      StHigh: begin
        if (tc) begin
          if (bit_cnt_q == '0) begin
            state_d = StHold;
          end else begin
            state_d = StLow;
            tx_sh_d = tx_sh_q << 1;
          end
        end
      end
      StHold: begin
        if (accept) begin
          rx_valid_d = 1'b1;
          rx_data_d  = (len_c == '0) ? '0 : rx_sh_q;
          state_d    = (len_c == '0) ? StDone : StSetup;
        end else if (tc) begin
          state_d    = StDone;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end
      end
      StDone: state_d = StGap;
      StGap: begin
        if (tc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cs_n_d     = !(state_d inside {StSetup, StHigh, StLow, StHold});
    sck_d      = (state_d == StHigh) ? !SckIdle : SckIdle;
    sdo_d      = (state_d inside {StSetup, StHigh, StLow}) ? tx_sh_d[DATA_WIDTH-1] : 1'b0;
    busy_d     = (state_d != StIdle);
    tx_ready_d = (state_d == StIdle) || (BurstEn && (state_d == StHold) && near_tc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= SckIdle;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sck      = sck_q;
  assign sdo      = sdo_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_initiator.sv
// Directed bench for spi_initiator with a simple mode-0 chip model or sdo->sdi loopback.
module tb_spi_initiator;

  localparam int unsigned DW = 16;
  localparam int unsigned H  = 4;
  localparam int unsigned LW = 5;

  logic          clk, reset_n;
  logic          tx_valid, tx_ready, rx_valid, busy, sck, sdo, sdi, cs_n;
  logic [DW-1:0] tx_data, rx_data;
  logic [LW-1:0] tx_len;

  int            n_checks, n_pass;
  logic          loopback;
  logic [15:0]   chip_word;
  int            chip_len;
  int            chip_idx;
  logic          chip_sdo;
  int            sck_rises;
  logic [15:0]   sdo_bits;

  spi_initiator #(
    .DATA_WIDTH (DW),
    .HALF_PERIOD(H),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .tx_len  (tx_len),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .busy    (busy),
    .sck     (sck),
    .sdo     (sdo),
    .sdi     (sdi),
    .cs_n    (cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Chip model: first bit valid at cs_n fall, next bit after each sck fall.
  always @(negedge sck or posedge cs_n) begin
    if (cs_n) chip_idx <= 0;
    else      chip_idx <= chip_idx + 1;
  end

  assign chip_sdo = (chip_idx < chip_len) ? chip_word[chip_len-1-chip_idx] : 1'b0;
  assign sdi      = loopback ? sdo : chip_sdo;

  always @(posedge sck) begin
    sck_rises <= sck_rises + 1;
    sdo_bits  <= {sdo_bits[14:0], sdo};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called just after a posedge with the DUT idle; returns measured timings and data.
  task automatic xfer(input logic [LW-1:0] len, input logic [DW-1:0] data,
                      output int lat, output int cs_low, output int rdy_lat,
                      output logic [DW-1:0] rx, output int extra_rv);
    int  k;
    bit  got;
    tx_data  = data;
    tx_len   = len;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    k = 1; cs_low = 0; got = 0; rx = '0; lat = -1;
    while (!got && k < 400) begin
      if (!cs_n) cs_low++;
      if (rx_valid) begin
        got = 1; lat = k; rx = rx_data;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    rdy_lat = -1; extra_rv = 0;
    for (int j = 1; j < 50; j++) begin
      @(posedge clk); #1;
      if (rx_valid) extra_rv++;
      if (tx_ready) begin
        rdy_lat = j;
        break;
      end
    end
  endtask

  initial begin
    int lat, cs_low, rdy, extra, base, k, rv, ch, ready_hi;
    logic [DW-1:0] rx;
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_len = '0;
    loopback = 1'b0; chip_word = '0; chip_len = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_sck", 32'(sck), 0);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit exchange against the chip model.
    chip_word = 16'h005A; chip_len = 8; base = sck_rises;
    xfer(5'd8, 16'h00AA, lat, cs_low, rdy, rx, extra);
    check("t1_latency", lat, 69);
    check("t1_cs_low", cs_low, 68);
    check("t1_rx_data", 32'(rx), 'h005A);
    check("t1_sck_rises", sck_rises - base, 8);
    check("t1_sdo_bits", 32'(sdo_bits[7:0]), 'hAA);
    check("t1_ready_lat", rdy, 5);
    check("t1_single_pulse", extra, 0);

    // Full-width loopback.
    loopback = 1'b1; base = sck_rises;
    xfer(5'd16, 16'h1234, lat, cs_low, rdy, rx, extra);
    check("t2_rx_data", 32'(rx), 'h1234);
    check("t2_sck_rises", sck_rises - base, 16);
    check("t2_latency", lat, 133);
    check("t2_cs_low", cs_low, 132);

    // Zero-length request: no bus activity.
    loopback = 1'b0; base = sck_rises;
    xfer(5'd0, 16'hFFFF, lat, cs_low, rdy, rx, extra);
    check("t3_latency", lat, 1);
    check("t3_cs_low", cs_low, 0);
    check("t3_rx_data", 32'(rx), 0);
    check("t3_sck_rises", sck_rises - base, 0);
    check("t3_ready_lat", rdy, 5);

    // Oversized length is clamped to the data width.
    loopback = 1'b1; base = sck_rises;
    xfer(5'd20, 16'hBEEF, lat, cs_low, rdy, rx, extra);
    check("t4_rx_data", 32'(rx), 'hBEEF);
    check("t4_sck_rises", sck_rises - base, 16);

    // Reset during the HIGH phase of bit 5.
    loopback = 1'b0; chip_word = 16'h0033; chip_len = 8; base = sck_rises;
    tx_data = 16'h00F0; tx_len = 5'd8; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    k = 0;
    while ((sck_rises - base) < 5 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_reach_bit5", sck_rises - base, 5);
    check("t5_sck_high", 32'(sck), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_cs_n", 32'(cs_n), 1);
    check("t5_async_sck", 32'(sck), 0);
    check("t5_async_busy", 32'(busy), 0);
    check("t5_async_tx_ready", 32'(tx_ready), 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rv = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (rx_valid) rv++;
    end
    check("t5_no_rx_valid", rv, 0);
    chip_word = 16'h00C3;
    xfer(5'd8, 16'h003C, lat, cs_low, rdy, rx, extra);
    check("t5_after_rx_data", 32'(rx), 'h00C3);
    check("t5_after_latency", lat, 69);

    // tx_valid held high; request fields change mid-word.
    loopback = 1'b1; tx_data = 16'h00A5; tx_len = 5'd8; tx_valid = 1'b1;
    @(posedge clk); #1;
    k = 1; ready_hi = 0;
    while (!rx_valid && k < 400) begin
      if (k == 10) begin
        tx_data = 16'hFFFF;
        tx_len  = 5'd3;
      end
      if (tx_ready) ready_hi++;
      @(posedge clk); #1;
      k++;
    end
    check("t6_latency", k, 69);
    check("t6_rx_data", 32'(rx_data), 'h00A5);
    check("t6_ready_low", ready_hi, 0);
`ifndef SPI_INITIATOR_BURST_EN
    ch = 0; ready_hi = 0;
    while (cs_n && ch < 50) begin
      ch++;
      if (tx_ready) ready_hi++;
      @(posedge clk); #1;
    end
    check("t6_cs_n_gap", ch, 6);
    check("t6_ready_window", ready_hi, 1);
`endif
    tx_valid = 1'b0;
    @(posedge clk); #1;
    k = 0;
    while (!rx_valid && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6_word2_rx_data", 32'(rx_data), 'h0007);
    k = 0;
    while (!tx_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("t6_idle_again", 32'(tx_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
